// File: rtl/res_st_issue.sv
// -----------------------------------------------------------------------------
// res_st_issue
// Reservation station that sits between the front end's rename-stage write
// port and a single execution unit. Each entry holds a micro-op plus two
// source operands. An operand is either ready (value captured) or waiting on
// a producer tag. Results broadcast on the common data bus (CDB) wake the
// waiting operands. The lowest-index entry with both operands ready is moved
// into a registered issue slot.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous squash of every entry and the issue slot
//   wr_*                front-end write port (one micro-op per cycle)
//   free_mask, full     occupancy view, taken from registered busy bits only
//   wr_collision        one-cycle pulse: the previous write hit a busy entry
//                       and was dropped
//   cdb_*               result broadcast (wake-up bus)
//   issue_*             registered issue port toward the execution unit
//
// Issue handshake: the execution unit takes a micro-op on any edge where
// issue_valid && issue_ready. While issue_valid is high and issue_ready is
// low, every issue_* output holds its value. The issue slot refills on an
// edge where it is empty or being drained (!issue_valid || issue_ready).
// -----------------------------------------------------------------------------
module res_st_issue #(
   parameter int DEPTH      = 8,
   parameter int TAG_WIDTH  = 6,
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 16,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [OP_WIDTH-1:0]   wr_op,
   input  logic [TAG_WIDTH-1:0]  wr_dst_tag,
   input  logic                  wr_rs1_rdy,
   input  logic                  wr_rs2_rdy,
   input  logic [TAG_WIDTH-1:0]  wr_rs1_tag,
   input  logic [TAG_WIDTH-1:0]  wr_rs2_tag,
   input  logic [DATA_WIDTH-1:0] wr_rs1_val,
   input  logic [DATA_WIDTH-1:0] wr_rs2_val,
   output logic [DEPTH-1:0]      free_mask,
   output logic                  full,
   output logic                  wr_collision,
   input  logic                  cdb_valid,
   input  logic [TAG_WIDTH-1:0]  cdb_tag,
   input  logic [DATA_WIDTH-1:0] cdb_data,
   output logic                  issue_valid,
   input  logic                  issue_ready,
   output logic [AW-1:0]         issue_addr,
   output logic [OP_WIDTH-1:0]   issue_op,
   output logic [TAG_WIDTH-1:0]  issue_dst_tag,
   output logic [DATA_WIDTH-1:0] issue_rs1_data,
   output logic [DATA_WIDTH-1:0] issue_rs2_data
);

   // Entry state: control bits carry reset, payload is plain datapath.
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      rs1_rdy;
   logic [DEPTH-1:0]      rs2_rdy;
   logic [OP_WIDTH-1:0]   op_q      [DEPTH];
   logic [TAG_WIDTH-1:0]  dst_q     [DEPTH];
   logic [TAG_WIDTH-1:0]  rs1_tag_q [DEPTH];
   logic [TAG_WIDTH-1:0]  rs2_tag_q [DEPTH];
   logic [DATA_WIDTH-1:0] rs1_val_q [DEPTH];
   logic [DATA_WIDTH-1:0] rs2_val_q [DEPTH];

   logic [DEPTH-1:0] cand;
   logic [DEPTH-1:0] wake1;
   logic [DEPTH-1:0] wake2;
   logic [AW-1:0]    sel;
   logic             found;
   logic             issue_open;
   logic             issue_load;
   logic             wr_accept;
   logic             fwd1;
   logic             fwd2;

   assign free_mask = ~busy;
   assign full      = &busy;

   // Selection looks only at registered state; a CDB hit this cycle makes the
   // entry a candidate on the following cycle.
   assign cand = busy & rs1_rdy & rs2_rdy;

   always_comb begin
      sel   = '0;
      found = |cand;
      // Scan downward so the lowest set index is the one left in sel.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (cand[i]) sel = AW'(i);
      end
   end

   assign issue_open = !issue_valid || issue_ready;
   assign issue_load = issue_open && found;

   // An entry leaving for the issue slot this edge is still busy here, so a
   // write aimed at it is dropped as a collision.
   assign wr_accept = wr_en && !busy[wr_addr];

   // Write-time forwarding: a broadcast in the same cycle as the write.
   assign fwd1 = !wr_rs1_rdy && cdb_valid && (cdb_tag == wr_rs1_tag);
   assign fwd2 = !wr_rs2_rdy && cdb_valid && (cdb_tag == wr_rs2_tag);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wake1[i] = cdb_valid && busy[i] && !rs1_rdy[i] && (rs1_tag_q[i] == cdb_tag);
         wake2[i] = cdb_valid && busy[i] && !rs2_rdy[i] && (rs2_tag_q[i] == cdb_tag);
      end
   end

   // Control bits: busy, operand-ready, collision pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy         <= '0;
         rs1_rdy      <= '0;
         rs2_rdy      <= '0;
         wr_collision <= 1'b0;
      end else if (flush) begin
         busy         <= '0;
         wr_collision <= 1'b0;
      end else begin
         wr_collision <= wr_en && busy[wr_addr];
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_accept && (wr_addr == AW'(i))) begin
               busy[i]    <= 1'b1;
               rs1_rdy[i] <= wr_rs1_rdy || fwd1;
               rs2_rdy[i] <= wr_rs2_rdy || fwd2;
            end else begin
               if (issue_load && (sel == AW'(i))) busy[i] <= 1'b0;
               if (wake1[i]) rs1_rdy[i] <= 1'b1;
               if (wake2[i]) rs2_rdy[i] <= 1'b1;
            end
         end
      end
   end

   // Payload: only ever read while the matching busy/rdy bits are set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_accept && (wr_addr == AW'(i))) begin
            op_q[i]      <= wr_op;
            dst_q[i]     <= wr_dst_tag;
            rs1_tag_q[i] <= wr_rs1_tag;
            rs2_tag_q[i] <= wr_rs2_tag;
            rs1_val_q[i] <= wr_rs1_rdy ? wr_rs1_val : cdb_data;
            rs2_val_q[i] <= wr_rs2_rdy ? wr_rs2_val : cdb_data;
         end else begin
            if (wake1[i]) rs1_val_q[i] <= cdb_data;
            if (wake2[i]) rs2_val_q[i] <= cdb_data;
         end
      end
   end

   // Issue register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_valid    <= 1'b0;
         issue_addr     <= '0;
         issue_op       <= '0;
         issue_dst_tag  <= '0;
         issue_rs1_data <= '0;
         issue_rs2_data <= '0;
      end else if (flush) begin
         issue_valid <= 1'b0;
      end else if (issue_load) begin
         issue_valid    <= 1'b1;
         issue_addr     <= sel;
         issue_op       <= op_q[sel];
         issue_dst_tag  <= dst_q[sel];
         issue_rs1_data <= rs1_val_q[sel];
         issue_rs2_data <= rs2_val_q[sel];
      end else if (issue_open) begin
         issue_valid <= 1'b0;
      end
   end

endmodule
